// File: rtl/alu_instr_encoder_if.sv
// Request/response bundle between an instruction producer and the ALU
// instruction encoder: request fields in, encoded word plus address out.
interface alu_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic        is_imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm12;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] addr;

  modport master (
    output in_valid, ALUControl, is_imm, rd, rs1, rs2, imm12, out_ready,
    input  in_ready, out_valid, instr, addr
  );

  modport slave (
    input  in_valid, ALUControl, is_imm, rd, rs1, rs2, imm12, out_ready,
    output in_ready, out_valid, instr, addr
  );
endinterface

// File: rtl/alu_instr_encoder.sv
// Encodes ALUControl requests into RV32I R/I-type ALU words, buffers them in a
// 2-entry FIFO and tags each with a sequential byte address.
module alu_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_instr_encoder_if.slave   bus,
  output logic                 err,
  output logic [ERR_W-1:0]     err_count
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  // There is no subi; the remaining undefined ALUControl codes have no encoding.
  function automatic logic is_legal(input logic [2:0] op, input logic imm);
    case (op)
      3'b000, 3'b010, 3'b011, 3'b101: is_legal = 1'b1;
      3'b001:                         is_legal = !imm;
      default:                        is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] encode(input logic [2:0] op, input logic imm,
                                         input logic [4:0] d, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [11:0] i12);
    logic [2:0] f3;
    logic [6:0] f7;
    case (op)
      3'b010:  f3 = 3'b111;
      3'b011:  f3 = 3'b110;
      3'b101:  f3 = 3'b010;
      default: f3 = 3'b000;
    endcase
    f7 = (op == 3'b001) ? 7'b0100000 : 7'b0000000;
    encode = imm ? {i12, s1, f3, d, OPC_I} : {f7, s2, s1, f3, d, OPC_R};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    sat_inc = (&c) ? c : c + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

  logic [31:0]      r_mem [0:1];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic [31:0]      r_addr;
  logic             r_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic w_full, w_empty, w_accept, w_legal, w_push, w_pop;

  assign w_full   = (r_count == 2'd2);
  assign w_empty  = (r_count == 2'd0);
  assign w_accept = bus.in_valid & !w_full;
  assign w_legal  = is_legal(bus.ALUControl, bus.is_imm);
  assign w_push   = w_accept & w_legal;
  assign w_pop    = !w_empty & bus.out_ready;

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = !w_empty;
  assign bus.instr     = r_mem[r_rptr];
  assign bus.addr      = r_addr;
  assign err           = r_err;
  assign err_count     = r_err_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mem[0]  <= 32'h0;
      r_mem[1]  <= 32'h0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
      r_addr    <= BASE_ADDR;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= encode(bus.ALUControl, bus.is_imm, bus.rd, bus.rs1,
                                bus.rs2, bus.imm12);
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
        r_addr <= r_addr + 32'd4;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      // Illegal requests still complete the handshake; they are only counted.
      if (w_accept && !w_legal) begin
        r_err     <= 1'b1;
        r_err_cnt <= sat_inc(r_err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Bench for alu_instr_encoder: directed scenarios plus random traffic against a
// queue-based reference model built from the RV32I field layout.
module tb_alu_instr_encoder;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          ERR_W   = 8;
  localparam int          CNT_MAX = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic reset_n;
  logic err;
  logic [ERR_W-1:0] err_count;

  always #5 clk = ~clk;

  alu_instr_encoder_if bus ();

  alu_instr_encoder #(.BASE_ADDR(BASE), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .err       (err),
    .err_count (err_count)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_q[$];
  logic [31:0] m_addr;
  logic        m_err;
  int          m_cnt;

  function automatic logic ref_legal(input logic [2:0] op, input logic imm);
    return (op == 3'd0) || (op == 3'd2) || (op == 3'd3) || (op == 3'd5) ||
           (op == 3'd1 && !imm);
  endfunction

  // Word assembled by weighting each field with its bit position.
  function automatic logic [31:0] ref_word(input logic [2:0] op, input logic imm,
                                           input logic [4:0] d, input logic [4:0] s1,
                                           input logic [4:0] s2, input logic [11:0] i12);
    logic [31:0] f3, w;
    case (op)
      3'd2:    f3 = 32'd7;
      3'd3:    f3 = 32'd6;
      3'd5:    f3 = 32'd2;
      default: f3 = 32'd0;
    endcase
    w = 32'(s1) * 32'h8000 + f3 * 32'h1000 + 32'(d) * 32'h80;
    if (imm) w = w + 32'(i12) * 32'h10_0000 + 32'h13;
    else     w = w + 32'(s2) * 32'h10_0000 + 32'h33 + ((op == 3'd1) ? 32'h4000_0000 : 32'h0);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    chk("in_ready",  32'(bus.in_ready),  32'(m_q.size() < 2));
    chk("addr",      bus.addr,           m_addr);
    chk("err",       32'(err),           32'(m_err));
    chk("err_count", 32'(err_count),     32'(m_cnt));
    if (m_q.size() != 0) chk("instr", bus.instr, m_q[0]);
  endtask

  // Drives one cycle of stimulus, advances the model across the edge, checks.
  task automatic step(input logic v, input logic [2:0] op, input logic im,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [11:0] i12, input logic ordy);
    bit acc, pop;
    bus.in_valid = v; bus.ALUControl = op; bus.is_imm = im; bus.rd = d;
    bus.rs1 = s1; bus.rs2 = s2; bus.imm12 = i12; bus.out_ready = ordy;
    acc = v && (m_q.size() < 2);
    pop = (m_q.size() != 0) && ordy;
    @(posedge clk); #1;
    if (pop) begin
      void'(m_q.pop_front());
      m_addr = m_addr + 32'd4;
    end
    if (acc) begin
      if (ref_legal(op, im)) m_q.push_back(ref_word(op, im, d, s1, s2, i12));
      else begin
        m_err = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    check_model();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0, ordy);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    m_q.delete(); m_addr = BASE; m_err = 1'b0; m_cnt = 0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr",     bus.instr,          32'h0);
    chk("rst_addr",      bus.addr,           BASE);
    chk("rst_err",       32'(err),           32'd0);
    chk("rst_err_count", 32'(err_count),     32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.ALUControl = 3'd0; bus.is_imm = 1'b0; bus.rd = 5'd0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.imm12 = 12'd0; bus.out_ready = 1'b0;
    do_reset();

    // single legal add
    step(1'b1, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1);
    chk("single_instr", bus.instr, 32'h002081B3);
    chk("single_addr",  bus.addr,  BASE);
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    idle(1'b1);
    chk("single_drain", 32'(bus.out_valid), 32'd0);

    // back-to-back stream
    do_reset();
    step(1'b1, 3'd1, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1);
    chk("s0_instr", bus.instr, 32'h402081B3); chk("s0_addr", bus.addr, BASE);
    step(1'b1, 3'd0, 1'b1, 5'd5, 5'd0, 5'd0, 12'hFFF, 1'b1);
    chk("s1_instr", bus.instr, 32'hFFF00293); chk("s1_addr", bus.addr, BASE + 32'd4);
    step(1'b1, 3'd3, 1'b1, 5'd6, 5'd5, 5'd0, 12'h0F0, 1'b1);
    chk("s2_instr", bus.instr, 32'h0F02E313); chk("s2_addr", bus.addr, BASE + 32'd8);
    step(1'b1, 3'd2, 1'b0, 5'd7, 5'd6, 5'd5, 12'd0, 1'b1);
    chk("s3_instr", bus.instr, 32'h005373B3); chk("s3_addr", bus.addr, BASE + 32'd12);
    idle(1'b1);

    // backpressure
    do_reset();
    step(1'b1, 3'd5, 1'b0, 5'd8, 5'd1, 5'd2, 12'd0, 1'b0);
    step(1'b1, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head", bus.instr, 32'h0020A433);
    step(1'b1, 3'd2, 1'b0, 5'd9, 5'd9, 5'd9, 12'd0, 1'b0);
    chk("bp_hold", bus.instr, 32'h0020A433);
    idle(1'b1);
    chk("bp_second", bus.instr, 32'h002081B3);
    chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
    idle(1'b1);

    // illegal requests
    do_reset();
    step(1'b1, 3'd1, 1'b1, 5'd3, 5'd1, 5'd0, 12'h001, 1'b1);
    step(1'b1, 3'd6, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1);
    chk("ill_valid", 32'(bus.out_valid), 32'd0);
    chk("ill_err",   32'(err), 32'd1);
    chk("ill_count", 32'(err_count), 32'd2);
    step(1'b1, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1);
    chk("ill_next_addr",  bus.addr,  BASE);
    chk("ill_next_instr", bus.instr, 32'h002081B3);
    idle(1'b1);

    // saturation
    do_reset();
    repeat (300) step(1'b1, 3'd7, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0, 1'b1);
    chk("sat_count", 32'(err_count), 32'd255);

    // reset mid-operation
    do_reset();
    step(1'b1, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0, 1'b1);
    step(1'b1, 3'd0, 1'b0, 5'd4, 5'd5, 5'd6, 12'd0, 1'b1);
    idle(1'b1);
    step(1'b1, 3'd3, 1'b0, 5'd7, 5'd8, 5'd9, 12'd0, 1'b0);
    step(1'b1, 3'd5, 1'b1, 5'd10, 5'd11, 5'd0, 12'h123, 1'b0);
    chk("mid_addr",  bus.addr, BASE + 32'd8);
    chk("mid_full",  32'(bus.in_ready), 32'd0);
    do_reset();

    // random traffic
    repeat (400)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom),
           1'($urandom_range(0, 3) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_instr_encoder.md
Name: alu_instr_encoder

Overview:
- Inverse of the ALU control decode path: takes a requested ALUControl operation plus register and immediate fields, and emits the matching 32-bit RV32I R-type or I-type ALU instruction word.
- Words leave through a 2-entry buffer with a valid/ready handshake, each tagged with a byte address.
- Used by the boot/test program loader to fill instruction memory.
- Flags and drops requests that have no legal encoding.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address tagged on the first emitted word after reset.
- ERR_W, 8, width of the saturating illegal-request counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  reset; synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request this cycle
- ALUControl  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- is_imm  in  1  1 = I-type (opcode 0010011), 0 = R-type (opcode 0110011)
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2 (R-type only)
- imm12  in  12  immediate (I-type only)
- out_valid  out  1  instruction word available
- out_ready  in  1  consumer takes the word
- instr  out  32  encoded instruction
- addr  out  32  byte address for instr
- err  out  1  sticky: an illegal request was seen
- err_count  out  ERR_W  number of illegal requests, saturating

Behaviour:
- Reset (reset_n low at a clk edge), regardless of in-flight traffic:
  - buffer emptied, so out_valid=0; instr=0.
  - addr=BASE_ADDR, err=0, err_count=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Accept: accept = in_valid & in_ready.
  - in_ready = !full. It depends only on registered occupancy, never on out_ready.
- Encoding (funct3 from ALUControl): add→000, sub→000, slt→010, or→110, and→111.
- R-type word = {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
  - funct7 = 7'b0100000 for sub, else 7'b0000000.
- I-type word = {imm12, rs1, funct3, rd, 7'b0010011}.
- Illegal requests: ALUControl ∈ {100, 110, 111}, or sub with is_imm=1 (no subi).
  - The request is accepted (handshake completes) but not pushed.
  - err set; err_count += 1, saturating at all-ones.
- Buffer: 2-entry FIFO of encoded words, encoded at push time.
  - A legal accept into an empty buffer gives out_valid=1 on the next cycle (latency 1).
  - out_valid = !empty.
  - instr shows the head entry; it holds stable while out_valid & !out_ready.
- Pop = out_valid & out_ready.
  - addr increments by 4 on each pop, wrapping modulo 2^32.
  - addr always shows the address of the current head.
- Simultaneous push and pop: occupancy unchanged, order preserved.
  - With 1 entry, the new word becomes head next cycle.
- Full (2 entries): in_ready=0. A pop that cycle frees a slot; in_ready returns to 1 the following cycle.
- Illegal accept in the same cycle as a pop: pop proceeds, nothing is pushed.
- x0 destination is legal and encoded as given.

Test Plan:
- Single legal request:
  - add rd=3, rs1=1, rs2=2, R-type, out_ready=1 → next cycle out_valid=1, instr=0x002081B3, addr=BASE_ADDR.
  - Following cycle out_valid=0.
- Back-to-back stream with out_ready=1 → words at addr 0, 4, 8, 12:
  - sub x3,x1,x2 → 0x402081B3
  - addi x5,x0,-1 (imm12=0xFFF) → 0xFFF00293
  - ori x6,x5,0x0F0 → 0x0F02E313
  - and x7,x6,x5 → 0x005373B3
- Backpressure:
  - Hold out_ready=0 and push slt x8,x1,x2 then add x3,x1,x2 → in_ready=0 after 2 accepts.
  - instr holds 0x0020A433 while stalled.
  - Release out_ready → 0x0020A433 then 0x002081B3, in order, no loss.
- Illegal requests:
  - sub with is_imm=1, then ALUControl=110 → both accepted, out_valid stays 0, err=1, err_count=2.
  - A following legal add is still emitted at addr=BASE_ADDR.
- Saturation: 300 illegal requests with ERR_W=8 → err_count=255.
- Reset mid-operation:
  - Assert reset_n=0 with 2 words buffered and addr=BASE_ADDR+8 → next cycle out_valid=0, addr=BASE_ADDR, err=0, err_count=0, in_ready=1.
